// File: rtl/adc_capture_sequencer.sv
// Periodic 3-channel ADC capture into a data-memory ring buffer, sharing the write port with the CPU.
// Optional `ADC_SEQ_WRAP_IRQ_EN adds a wrapIrq pulse when the ring index wraps.
module adc_capture_sequencer #(
    parameter int unsigned PERIOD    = 1000,
    parameter logic [9:0]  BASE_ADDR = 10'd992,
    parameter int unsigned BUF_DEPTH = 32,
    localparam int unsigned IdxW     = $clog2(BUF_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clearOverrun,
    input  logic [7:0]      ADC0,
    input  logic [7:0]      ADC1,
    input  logic [7:0]      ADC2,
    input  logic            cpuWE,
    input  logic [9:0]      cpuWriteAddr,
    input  logic [23:0]     cpuWriteData,
    output logic            memWE,
    output logic [9:0]      memWriteAddr,
    output logic [23:0]     memWriteData,
    output logic [IdxW-1:0] writeIndex,
    output logic            sampleDone,
    output logic            overrun
`ifdef ADC_SEQ_WRAP_IRQ_EN
    ,
    output logic            wrapIrq
`endif
);

    localparam int unsigned CntW = $clog2(PERIOD);

    typedef enum logic {StIdle, StPending} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [23:0]     word_q, word_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;
    logic            tick, commit, drop;
`ifdef ADC_SEQ_WRAP_IRQ_EN
    logic            wrap_q, wrap_d;
`endif

    assign tick   = enable && (cnt_q == CntW'(PERIOD - 1));
    assign commit = (state_q == StPending) && !cpuWE;
    assign drop   = (state_q == StPending) && cpuWE && tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef ADC_SEQ_WRAP_IRQ_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
`ifdef ADC_SEQ_WRAP_IRQ_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        done_d  = commit;
        cnt_d   = (!enable || tick) ? '0 : cnt_q + 1'b1;
        // A drop in the same cycle as a clear leaves the flag set.
        ovr_d   = drop ? 1'b1 : (clearOverrun ? 1'b0 : ovr_q);
`ifdef ADC_SEQ_WRAP_IRQ_EN
        wrap_d  = commit && (idx_q == IdxW'(BUF_DEPTH - 1));
`endif
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    word_d  = {ADC2, ADC1, ADC0};
                    state_d = StPending;
                end
            end
            StPending: begin
                if (!cpuWE) begin
                    idx_d = (idx_q == IdxW'(BUF_DEPTH - 1)) ? '0 : idx_q + 1'b1;
                    if (tick) begin
                        word_d = {ADC2, ADC1, ADC0};
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The CPU always owns the port when it writes; the sequencer fills idle slots only.
    always_comb begin
        memWE        = cpuWE;
        memWriteAddr = cpuWriteAddr;
        memWriteData = cpuWriteData;
        if (!cpuWE && (state_q == StPending)) begin
            memWE        = 1'b1;
            memWriteAddr = BASE_ADDR + 10'(idx_q);
            memWriteData = word_q;
        end
    end

    assign writeIndex = idx_q;
    assign sampleDone = done_q;
    assign overrun    = ovr_q;
`ifdef ADC_SEQ_WRAP_IRQ_EN
    assign wrapIrq    = wrap_q;
`endif

endmodule
